// File: rtl/mantle_slices_pkg.sv
// Shared defaults and index types for the slice pipeline.
// Also provides the index-width helper used to size the channel-select port.
package mantle_slices_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 9;
  localparam int NCH_DEF   = 2;
  localparam int LEN_DEF   = 4;
  localparam int WRAP_DEF  = 1;

  localparam int OFF_W_DEF = $clog2(DEPTH_DEF);
  localparam int CH_W_DEF  = (NCH_DEF > 1) ? $clog2(NCH_DEF) : 1;

  typedef logic [OFF_W_DEF-1:0] off_idx_t;
  typedef logic [CH_W_DEF-1:0]  ch_idx_t;

  // A select field for a single item still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mantle_slice_sel.sv
// Combinational selector: LEN consecutive elements of in_arr starting at off.
// Out-of-range elements wrap modulo DEPTH, or read as zero and raise err when WRAP=0.
module mantle_slice_sel
  import mantle_slices_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LEN   = LEN_DEF,
  parameter int WRAP  = WRAP_DEF
) (
  input  logic [WIDTH-1:0]         in_arr [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] off,
  output logic [WIDTH-1:0]         slice  [LEN],
  output logic                     err
);

  localparam int OFF_W = $clog2(DEPTH);
  // off and k are both below DEPTH, so one extra bit holds their sum and a
  // single subtraction of DEPTH is enough to wrap it.
  localparam int SW = OFF_W + 1;

  logic [LEN-1:0] oor;

  for (genvar k = 0; k < LEN; k++) begin : g_elem
    logic [SW-1:0]    sum;
    logic [OFF_W-1:0] idx;

    assign sum      = SW'(off) + SW'(k);
    assign oor[k]   = (sum >= SW'(DEPTH));
    assign idx      = OFF_W'(oor[k] ? (sum - SW'(DEPTH)) : sum);
    assign slice[k] = (oor[k] && (WRAP == 0)) ? '0 : in_arr[idx];
  end

  assign err = (WRAP == 0) && (|oor);

endmodule

// File: rtl/mantle_slices_pipe.sv
// Per-channel slice capture into a 2-entry output FIFO; data visible one cycle after accept.
// I_ready is registered and low only while two beats are held; O holds steady under stall.
module mantle_slices_pipe
  import mantle_slices_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int LEN   = LEN_DEF,
  parameter int WRAP  = WRAP_DEF
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESETN,
  input  logic [WIDTH-1:0]         I [DEPTH],
  input  logic                     I_valid,
  output logic                     I_ready,
  output logic [WIDTH-1:0]         O [NCH][LEN],
  output logic                     O_valid,
  input  logic                     O_ready,
  output logic [NCH-1:0]           O_err,
  input  logic                     cfg_we,
  input  logic [idx_w(NCH)-1:0]    cfg_ch,
  input  logic [$clog2(DEPTH)-1:0] cfg_off
);

  localparam int OFF_W = $clog2(DEPTH);

  logic [OFF_W-1:0] off_q   [NCH];
  logic [WIDTH-1:0] sel_dat [NCH][LEN];
  logic [NCH-1:0]   sel_err;

  logic [WIDTH-1:0] mem_dat [2][NCH][LEN];
  logic [NCH-1:0]   mem_err [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic [1:0]       cnt_nxt;
  logic             rdy_q;
  logic             push;
  logic             pop;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    mantle_slice_sel #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .LEN   (LEN),
      .WRAP  (WRAP)
    ) u_sel (
      .in_arr (I),
      .off    (off_q[c]),
      .slice  (sel_dat[c]),
      .err    (sel_err[c])
    );
  end

  // Writes naming a nonexistent offset or channel match nothing and are dropped.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int c = 0; c < NCH; c++) off_q[c] <= '0;
    end else if (cfg_we && (32'(cfg_off) < DEPTH)) begin
      for (int c = 0; c < NCH; c++) begin
        if (32'(cfg_ch) == c) off_q[c] <= cfg_off;
      end
    end
  end

  assign push = I_valid && rdy_q;
  assign pop  = O_valid && O_ready;

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + 2'd1;
    else if (!push && pop) cnt_nxt = cnt - 2'd1;
  end

  // rdy_q is held low through reset so I_ready rises on the first edge after release.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      rdy_q  <= 1'b0;
      for (int e = 0; e < 2; e++) begin
        mem_err[e] <= '0;
        for (int c = 0; c < NCH; c++)
          for (int k = 0; k < LEN; k++) mem_dat[e][c][k] <= '0;
      end
    end else begin
      if (push) begin
        mem_err[wr_ptr] <= sel_err;
        for (int c = 0; c < NCH; c++)
          for (int k = 0; k < LEN; k++) mem_dat[wr_ptr][c][k] <= sel_dat[c][k];
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt   <= cnt_nxt;
      rdy_q <= (cnt_nxt != 2'd2);
    end
  end

  assign I_ready = rdy_q;
  assign O_valid = (cnt != 2'd0);

  always_comb begin
    O_err = mem_err[rd_ptr];
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < LEN; k++) O[c][k] = mem_dat[rd_ptr][c][k];
  end

endmodule

// File: doc/mantle_slices_pipe.md
MANTLE_SLICES_PIPE -- requirements
Module: mantle_slices_pipe

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the bit width of one array element.
REQ-002 Parameter DEPTH, default 9, SHALL set the number of input elements (DEPTH >= 2).
REQ-003 Parameter NCH, default 2, SHALL set the number of output slice channels (NCH >= 1).
REQ-004 Parameter LEN, default 4, SHALL set the number of elements per channel slice (1 <= LEN <= DEPTH).
REQ-005 Parameter WRAP, default 1, SHALL select out-of-range handling: 1 means modulo-DEPTH indexing, 0 means zero-fill with error flag.
REQ-006 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-007 Ports, in order (name, direction, width, meaning):
- CLK, in, 1: single clock, rising edge.
- ASYNCRESETN, in, 1: asynchronous active-low reset.
- I, in, [WIDTH-1:0] x DEPTH unpacked: input element array.
- I_valid, in, 1: input beat offered.
- I_ready, out, 1: input beat acceptable.
- O, out, [WIDTH-1:0] x LEN x NCH unpacked: channel slices.
- O_valid, out, 1: output beat present.
- O_ready, in, 1: consumer accepts output beat.
- O_err, out, NCH: per-channel out-of-range flag for the current O beat.
- cfg_we, in, 1: offset write strobe.
- cfg_ch, in, max(1,$clog2(NCH)): target channel.
- cfg_off, in, $clog2(DEPTH): new start offset.

Function
REQ-008 Input accept SHALL occur on a rising edge with I_valid && I_ready; output pop SHALL occur on a rising edge with O_valid && O_ready.
REQ-009 Each channel c SHALL hold an offset register off[c]; an accepted beat SHALL capture slice element k of channel c from index off[c]+k, k = 0..LEN-1.
REQ-010 With WRAP=1, the index SHALL be (off[c]+k) mod DEPTH, and O_err[c] SHALL be 0.
REQ-011 With WRAP=0 and off[c]+k >= DEPTH, element k SHALL be all-zero, and O_err[c] SHALL be 1 for that beat.
REQ-012 Slice data and O_err SHALL be captured into a 2-entry FIFO at the accept edge; latency from accept edge to O_valid high with that data SHALL be one cycle.
REQ-013 I_ready SHALL be 1 exactly when the FIFO holds fewer than 2 entries, and SHALL be driven from registered state only.
REQ-014 O_valid SHALL be 1 exactly when the FIFO is non-empty; O and O_err SHALL present the head entry and SHALL stay stable while O_valid && !O_ready.
REQ-015 Simultaneous accept and pop with 1 entry SHALL leave occupancy 1 and present the new beat next cycle; sustained throughput SHALL be one beat per cycle.
REQ-016 With the FIFO full, I_ready SHALL be 0 and no beat SHALL be captured, even when O_ready=1 that cycle.
REQ-017 cfg_we SHALL write off[cfg_ch] at the rising edge; a beat accepted on the same edge SHALL use the old offset.
REQ-018 A write with cfg_off >= DEPTH or cfg_ch >= NCH SHALL be ignored, leaving all offsets unchanged.
REQ-019 Offset changes SHALL NOT alter entries already held in the FIFO.

Reset
REQ-020 Asserting ASYNCRESETN low SHALL immediately empty the FIFO, forcing O_valid=0, I_ready=0, O_err=0, O=0, and off[c]=0 for all c.
REQ-021 I_ready SHALL rise on the first rising edge after ASYNCRESETN deasserts; reset mid-transfer SHALL discard all held beats.

Structure
REQ-022 Package mantle_slices_pkg SHALL hold parameter defaults, the offset index type, and the channel index type.
REQ-023 Sub-module mantle_slice_sel SHALL be the combinational per-channel selector (I, off, WRAP -> LEN elements plus error bit), instantiated NCH times.
REQ-024 Registers SHALL be limited to the offset bank, the 2-entry FIFO storage, and the FIFO pointers/count.

Verification (defaults unless stated; I[k]=0x100+k)
REQ-025 Default offsets, one beat, O_ready=1 -> next cycle O[0]=O[1]={0x100..0x103}, O_err=0.
REQ-026 off[0]=3, off[1]=6, WRAP=1 -> O[0]={0x103..0x106}, O[1]={0x106,0x107,0x108,0x100}, O_err=0.
REQ-027 Same offsets with WRAP=0 -> O[1]={0x106,0x107,0x108,0}, O_err=2'b10.
REQ-028 O_ready=0, I_valid held high for 3 cycles -> exactly 2 beats accepted, I_ready=0, O stable; one pop -> I_ready=1 next cycle.
REQ-029 cfg_we with off[0]=5 on the same edge as an accept -> that beat uses offset 0, and the next beat uses 5; cfg_off=9 -> ignored.
REQ-030 ASYNCRESETN low asynchronously with 2 beats held -> O_valid=0 before the next edge; offsets return to 0.
